reg_writeback_arbiter: RTL

- Producer side of the register-file write port. Merges single-cycle ALU results with returning multi-cycle load data and drives one registered write (WriteRegister/WriteData/RegWrite) per cycle.
- Buffers load returns that collide with ALU writes in a small FIFO.
- Keeps a 32-entry pending-load scoreboard, queried by decode for RAW hazard stalls.

---
 rtl/mips_wb_pkg.sv | 21 ++
 rtl/wb_fifo.sv | 60 ++++++
 rtl/reg_writeback_arbiter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/mips_wb_pkg.sv
// Shared types and constants for the register-file writeback path.
package mips_wb_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    // One register-file write: destination index plus data.
    typedef struct packed {
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    // Which producer owns the write port in a given cycle.
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ALU  = 2'd1,
        SRC_LD   = 2'd2
    } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of writeback requests used to park load returns
// that lose the write port to the ALU. LD_DEPTH must be a power of two so
// the pointers wrap naturally; the count is one bit wider than a pointer.
module wb_fifo
    import mips_wb_pkg::*;
#(
    parameter int LD_DEPTH = 2
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    push,
    input  logic    pop,
    input  wb_req_t din,
    output wb_req_t head,
    output logic    full,
    output logic    empty
);

    localparam int PW = $clog2(LD_DEPTH);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    wb_req_t       mem [LD_DEPTH];

    logic push_ok;
    logic pop_ok;

    // Overflow/underflow are blocked here too, so a misbehaving caller
    // cannot corrupt the count.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    assign full  = (count == (PW+1)'(LD_DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves the count alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents need no reset because the count gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/reg_writeback_arbiter.sv
// Register-file write port producer. ALU results always win the port; load
// returns that collide are parked in wb_fifo and drained on idle ALU cycles.
// A pending-load scoreboard feeds decode hazard checks.
// Optional feature: define WB_LD_BYPASS_EN to let a load arriving at an
// empty FIFO on an ALU-idle cycle skip the FIFO (1-cycle load latency).
module reg_writeback_arbiter #(
    parameter int LD_DEPTH = 2,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_dest,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_dest,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              iss_load,
    input  logic [ADDR_W-1:0] iss_dest,
    output logic              iss_stall,
    input  logic [ADDR_W-1:0] query_reg1,
    input  logic [ADDR_W-1:0] query_reg2,
    output logic              pending1,
    output logic              pending2,
    output logic [ADDR_W-1:0] WriteRegister,
    output logic [DATA_W-1:0] WriteData,
    output logic              RegWrite,
    output logic              waw_err
);

    import mips_wb_pkg::*;

    wb_req_t alu_req;
    wb_req_t ld_req;
    wb_req_t fifo_head;
    wb_req_t sel_req;
    wb_src_e sel_src;

    logic fifo_full;
    logic fifo_empty;
    logic fifo_push;
    logic fifo_pop;
    logic ld_acc;
    logic ld_byp;
    logic iss_acc;

    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;

    assign alu_req = '{dest: alu_dest, data: alu_data};
    assign ld_req  = '{dest: ld_dest,  data: ld_data};

    // ---------------------------------------------------------------
    // Load return handshake
    // ---------------------------------------------------------------
    assign ld_ready = !fifo_full;
    assign ld_acc   = ld_valid && ld_ready;

`ifdef WB_LD_BYPASS_EN
    // Only bypass when nothing older is queued, so load order is kept.
    assign ld_byp = ld_acc && fifo_empty && !alu_valid;
`else
    assign ld_byp = 1'b0;
`endif

    assign fifo_push = ld_acc && !ld_byp;

    wb_fifo #(
        .LD_DEPTH (LD_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (ld_req),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // ---------------------------------------------------------------
    // Source select: ALU cannot stall, queued loads next, bypass last
    // ---------------------------------------------------------------
    // Pick the single producer that owns the write port this cycle.
    always_comb begin
        sel_src  = SRC_NONE;
        sel_req  = alu_req;
        fifo_pop = 1'b0;
        if (alu_valid) begin
            sel_src = SRC_ALU;
            sel_req = alu_req;
        end else if (!fifo_empty) begin
            sel_src  = SRC_LD;
            sel_req  = fifo_head;
            fifo_pop = 1'b1;
        end else if (ld_byp) begin
            sel_src = SRC_LD;
            sel_req = ld_req;
        end
    end

    // Register the selected write; r0 writes are consumed but never strobed,
    // and idle cycles keep the last index/data on the bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            RegWrite      <= 1'b0;
            WriteRegister <= '0;
            WriteData     <= '0;
        end else begin
            RegWrite <= (sel_src != SRC_NONE) && (sel_req.dest != '0);
            if (sel_src != SRC_NONE) begin
                WriteRegister <= sel_req.dest;
                WriteData     <= sel_req.data;
            end
        end
    end

    // ---------------------------------------------------------------
    // Pending-load scoreboard
    // ---------------------------------------------------------------
    assign iss_stall = iss_load && (iss_dest != '0) && pending_q[iss_dest];
    assign iss_acc   = iss_load && (iss_dest != '0) && !pending_q[iss_dest];

    assign pending1 = (query_reg1 != '0) && pending_q[query_reg1];
    assign pending2 = (query_reg2 != '0) && pending_q[query_reg2];

    // Clear on load writeback, then apply the new issue so a same-register set wins.
    always_comb begin
        pending_d = pending_q;
        if (sel_src == SRC_LD) pending_d[sel_req.dest] = 1'b0;
        if (iss_acc)           pending_d[iss_dest]     = 1'b1;
        pending_d[0] = 1'b0;
    end

    // Scoreboard state.
    always_ff @(posedge clk) begin
        if (reset) pending_q <= '0;
        else       pending_q <= pending_d;
    end

    // Sticky flag: an ALU write overtook a still-outstanding load to the same register.
    always_ff @(posedge clk) begin
        if (reset)
            waw_err <= 1'b0;
        else if (alu_valid && (alu_dest != '0) && pending_q[alu_dest])
            waw_err <= 1'b1;
    end

endmodule
